// File: rtl/div_req_scheduler_pkg.sv
// Shared types for the divider request scheduler: FSM states, queued request record, DBZ quotient.
// DIV_SIZE is the operand width the request record is built for; instantiate the scheduler with SIZE equal to it.
package div_req_scheduler_pkg;

  localparam int unsigned DIV_SIZE = 32;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} sched_state_t;

  typedef struct packed {
    logic [DIV_SIZE-1:0] num;
    logic [DIV_SIZE-1:0] den;
  } div_req_t;

  // Quotient reported for a zero divisor: all ones, matching what a restoring divider would produce.
  function automatic logic [DIV_SIZE-1:0] dbz_coc();
    return '1;
  endfunction

endpackage

// File: rtl/div_req_scheduler_if.sv
// Request, divider and result handshakes of the scheduler; slave is the scheduler side, master the environment.
interface div_req_scheduler_if #(
  parameter int unsigned SIZE  = 32,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] in_num;
  logic [SIZE-1:0] in_den;
  logic            div_start;
  logic [SIZE-1:0] div_num;
  logic [SIZE-1:0] div_den;
  logic            div_done;
  logic [SIZE-1:0] div_coc;
  logic [SIZE-1:0] div_resto;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] out_coc;
  logic [SIZE-1:0] out_resto;
  logic            out_dbz;
  logic            out_err;
  logic [CW-1:0]   fifo_count;

  modport slave (
    input  in_valid, in_num, in_den, div_done, div_coc, div_resto, out_ready,
    output in_ready, div_start, div_num, div_den, out_valid, out_coc, out_resto,
           out_dbz, out_err, fifo_count
  );

  modport master (
    output in_valid, in_num, in_den, div_done, div_coc, div_resto, out_ready,
    input  in_ready, div_start, div_num, div_den, out_valid, out_coc, out_resto,
           out_dbz, out_err, fifo_count
  );
endinterface

// File: rtl/div_req_fifo.sv
// First-word-fall-through request queue; head visible combinationally, one push and one pop per cycle.
// Pushes while full and pops while empty are dropped, so callers may present raw requests.
module div_req_fifo
  import div_req_scheduler_pkg::*;
#(
  parameter int unsigned SIZE  = DIV_SIZE,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [2*SIZE-1:0] din,
  output logic [2*SIZE-1:0] dout,
  output logic            full,
  output logic            empty,
  output logic [CW-1:0]   count
);

  div_req_t          mem_q [DEPTH];
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/div_req_scheduler.sv
// Queues divide requests and runs them one at a time on an external divider; DBZ answered locally.
// Request to start: 2 edges; result held until out_ready; a hung divider is aborted after TIMEOUT WAIT cycles.
module div_req_scheduler
  import div_req_scheduler_pkg::*;
#(
  parameter int unsigned SIZE    = DIV_SIZE,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 2 * SIZE + 8
) (
  input logic              clk,
  input logic              rst,
  div_req_scheduler_if.slave bus
);

  localparam int unsigned CW  = $clog2(DEPTH) + 1;
  localparam int unsigned WDW = $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  sched_state_t    state_q, state_d;
  logic [SIZE-1:0] num_q, num_d, den_q, den_d;
  logic [SIZE-1:0] coc_q, coc_d, resto_q, resto_d;
  logic            dbz_q, dbz_d, err_q, err_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic            pop, fifo_full, fifo_empty;
  logic [CW-1:0]   count;
  div_req_t        head;

  div_req_fifo #(.SIZE(SIZE), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.in_valid),
    .pop   (pop),
    .din   ({bus.in_num, bus.in_den}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign bus.in_ready   = ~fifo_full;
  assign bus.fifo_count = count;
  assign bus.div_start  = (state_q == ISSUE);
  assign bus.div_num    = num_q;
  assign bus.div_den    = den_q;
  assign bus.out_valid  = (state_q == HOLD);
  assign bus.out_coc    = coc_q;
  assign bus.out_resto  = resto_q;
  assign bus.out_dbz    = dbz_q;
  assign bus.out_err    = err_q;

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    den_d   = den_q;
    coc_d   = coc_q;
    resto_d = resto_q;
    dbz_d   = dbz_q;
    err_d   = err_q;
    wd_d    = wd_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head.den != '0) begin
            num_d   = head.num;
            den_d   = head.den;
            state_d = ISSUE;
          end else begin
            coc_d   = dbz_coc();
            resto_d = head.num;
            dbz_d   = 1'b1;
            state_d = HOLD;
          end
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Completion wins over the watchdog when both land on the same edge.
        if (bus.div_done) begin
          coc_d   = bus.div_coc;
          resto_d = bus.div_resto;
          state_d = HOLD;
        end else if (wd_q == WD_LAST) begin
          coc_d   = '0;
          resto_d = '0;
          err_d   = 1'b1;
          state_d = HOLD;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          dbz_d   = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      num_q   <= '0;
      den_q   <= '0;
      coc_q   <= '0;
      resto_q <= '0;
      dbz_q   <= 1'b0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      den_q   <= den_d;
      coc_q   <= coc_d;
      resto_q <= resto_d;
      dbz_q   <= dbz_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

endmodule

// File: tb/tb_div_req_scheduler.sv
// Directed bench: a divider model answers starts after DIV_LAT cycles; a monitor scores results in order.
module tb_div_req_scheduler;

  localparam int SIZE    = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 2 * SIZE + 8;
  localparam int DIV_LAT = 3;

  typedef struct packed {
    logic [SIZE-1:0] coc;
    logic [SIZE-1:0] resto;
    logic            dbz;
    logic            err;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_req_scheduler_if #(.SIZE(SIZE), .DEPTH(DEPTH)) bus ();

  div_req_scheduler #(.SIZE(SIZE), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  res_t exp_q[$];
  res_t mon_e;
  int   n_checks = 0;
  int   n_err    = 0;
  int   epoch    = 0;
  bit   hang_next = 1'b0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic res_t mk(input logic [SIZE-1:0] c, input logic [SIZE-1:0] r,
                              input logic dbz, input logic err);
    res_t t;
    t.coc = c; t.resto = r; t.dbz = dbz; t.err = err;
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [SIZE-1:0] n, input logic [SIZE-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_num   = n;
    bus.in_den   = d;
    chk("push_in_ready", {79'd0, bus.in_ready}, 80'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int lim);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < lim) begin
      step();
      k++;
    end
    chk("drain_pending", 80'(exp_q.size()), 80'd0);
  endtask

  // Divider model: answers each start after DIV_LAT edges unless told to hang.
  initial begin
    logic [SIZE-1:0] n, d;
    int ep;
    bus.div_done  = 1'b0;
    bus.div_coc   = '0;
    bus.div_resto = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.div_start) begin
        if (hang_next) begin
          hang_next = 1'b0;
        end else begin
          n  = bus.div_num;
          d  = bus.div_den;
          ep = epoch;
          repeat (DIV_LAT) @(posedge clk);
          #1;
          if (ep == epoch)
            chk("div_operands_held", {16'd0, bus.div_num, bus.div_den}, {16'd0, n, d});
          bus.div_done  = 1'b1;
          bus.div_coc   = n / d;
          bus.div_resto = n % d;
          @(posedge clk);
          #1;
          bus.div_done = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_result: got coc=%0h resto=%0h expected no result",
                 bus.out_coc, bus.out_resto);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result", {14'd0, bus.out_coc, bus.out_resto, bus.out_dbz, bus.out_err},
            {14'd0, mon_e});
      end
    end
  end

  initial begin
    logic [SIZE-1:0] nums [5];
    logic [SIZE-1:0] dens [5];
    logic [SIZE-1:0] qs   [5];
    logic [SIZE-1:0] rs   [5];
    int k;
    bit seen;
    nums = '{32'd1000, 32'd77, 32'd9, 32'd0, 32'hFFFF_FFFF};
    dens = '{32'd10,   32'd5,  32'd10, 32'd3, 32'd1};
    qs   = '{32'd100,  32'd15, 32'd0,  32'd0, 32'hFFFF_FFFF};
    rs   = '{32'd0,    32'd2,  32'd9,  32'd0, 32'd0};

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_num    = '0;
    bus.in_den    = '0;
    bus.out_ready = 1'b0;
    repeat (3) step();
    chk("rst_fifo_count", 80'(bus.fifo_count), 80'd0);
    chk("rst_div", {15'd0, bus.div_start, bus.div_num, bus.div_den}, 80'd0);
    chk("rst_out", {13'd0, bus.out_valid, bus.out_coc, bus.out_resto, bus.out_dbz, bus.out_err}, 80'd0);
    rst = 1'b0;
    step();
    chk("in_ready_after_rst", {79'd0, bus.in_ready}, 80'd1);

    // Single normal request.
    bus.out_ready = 1'b1;
    exp_q.push_back(mk(32'd14, 32'd2, 1'b0, 1'b0));
    push(32'd100, 32'd7);
    chk("t1_count_after_push", 80'(bus.fifo_count), 80'd1);
    chk("t1_no_start_yet", {79'd0, bus.div_start}, 80'd0);
    step();
    chk("t1_issue", {15'd0, bus.div_start, bus.div_num, bus.div_den}, {15'd0, 1'b1, 32'd100, 32'd7});
    step();
    chk("t1_start_one_cycle", {79'd0, bus.div_start}, 80'd0);
    wait_drain(20);

    // Divide by zero.
    exp_q.push_back(mk(32'hFFFF_FFFF, 32'd55, 1'b1, 1'b0));
    push(32'd55, 32'd0);
    chk("t2_valid_early", {79'd0, bus.out_valid}, 80'd0);
    step();
    chk("t2_dbz_out", {46'd0, bus.out_valid, bus.div_start, bus.out_coc},
        {46'd0, 1'b1, 1'b0, 32'hFFFF_FFFF});
    wait_drain(10);

    // Fill the queue behind a held result.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(mk(qs[i], rs[i], 1'b0, 1'b0));
      push(nums[i], dens[i]);
    end
    chk("t3_full_count", 80'(bus.fifo_count), 80'd4);
    chk("t3_full_not_ready", {79'd0, bus.in_ready}, 80'd0);
    bus.in_valid = 1'b1;
    bus.in_num   = 32'd123;
    bus.in_den   = 32'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_push_ignored", {75'd0, bus.in_ready, bus.fifo_count}, {75'd0, 1'b0, 4'd4});
    end
    bus.in_valid = 1'b0;
    k = 0;
    while (!bus.out_valid && k < 50) begin
      step();
      k++;
    end
    chk("t3_hold_reached", {79'd0, bus.out_valid}, 80'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t3_hold_stable",
          {12'd0, bus.out_valid, bus.div_start, bus.out_dbz, bus.out_err, bus.out_coc, bus.out_resto},
          {12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd100, 32'd0});
      chk("t3_operands_held", {16'd0, bus.div_num, bus.div_den}, {16'd0, 32'd1000, 32'd10});
    end
    bus.out_ready = 1'b1;
    step();
    chk("t3_release_idle", {79'd0, bus.div_start}, 80'd0);
    step();
    chk("t3_next_start", {47'd0, bus.div_start, bus.div_num}, {47'd0, 1'b1, 32'd77});
    wait_drain(100);

    // Hung divider followed by a healthy request.
    exp_q.push_back(mk(32'd0, 32'd0, 1'b0, 1'b1));
    exp_q.push_back(mk(32'd6, 32'd2, 1'b0, 1'b0));
    hang_next = 1'b1;
    push(32'd12, 32'd4);
    push(32'd50, 32'd8);
    step();
    repeat (TIMEOUT - 1) step();
    chk("t4_not_before_timeout", {79'd0, bus.out_valid}, 80'd0);
    step();
    chk("t4_timeout_result", {14'd0, bus.out_valid, bus.out_err, bus.out_coc, bus.out_resto},
        {14'd0, 1'b1, 1'b1, 32'd0, 32'd0});
    wait_drain(50);

    // Reset while an op waits with two more queued.
    push(32'd90, 32'd9);
    push(32'd8, 32'd3);
    push(32'd7, 32'd2);
    chk("t5_queued", 80'(bus.fifo_count), 80'd2);
    rst = 1'b1;
    epoch++;
    step();
    chk("t5_after_rst", {77'd0, bus.fifo_count == 3'd0, bus.out_valid, bus.div_start},
        {77'd0, 1'b1, 1'b0, 1'b0});
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      step();
      if (bus.out_valid || bus.div_start) seen = 1'b1;
    end
    chk("t5_no_stale_activity", {79'd0, seen}, 80'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
